add_share_sched: RTL and testbench
==================================

Name: add_share_sched

Overview:
- Time-multiplexes one fixed-point adder datapath between N_REQ requesters.
- The adder does sign-extend, add, format-match to OUT_W, then a registered delay line.
- Per-cycle round-robin arbitration with valid/ready on the request side.
- Fixed-latency, tagged result bus on the output side; sits between the operand producers and the shared adder pipeline.

Parameters:
N_REQ, 4, number of requesters (2..8)
IN_W, 13, signed operand width (two's complement)
OUT_W, 12, signed result width; OUT_W <= IN_W+1
LAT, 2, result pipeline depth in cycles from grant to o_res_valid (>=1)
TAG_W, 2, requester-index width = ceil(log2(N_REQ))

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  N_REQ  per-requester operand valid
o_req_ready  out  N_REQ  per-requester grant/accept (one-hot or zero)
i_req_a  in  N_REQ*IN_W  operand A, requester k at bits [k*IN_W +: IN_W]
i_req_b  in  N_REQ*IN_W  operand B, same packing
i_hold  in  1  suspend new grants; pipeline keeps draining
o_res_valid  out  1  result valid (one-cycle pulse per accepted request)
o_res_tag  out  TAG_W  index of requester that owns o_res_data
o_res_data  out  OUT_W  formatted sum
o_busy  out  1  high while any accepted op is still in flight

Behaviour:
- Reset (i_rst_n low, async):
  - o_req_ready=0, o_res_valid=0, o_res_tag=0, o_res_data=0, o_busy=0.
  - RR pointer=0; all pipeline valid bits cleared.
  - Reset mid-operation discards in-flight ops: no result is ever emitted for them.
- Arbitration is combinational within the cycle; o_req_ready depends on i_req_valid, i_hold and the pointer.
  - i_hold=1 or no valid -> o_req_ready=0.
  - Else grant the first k with i_req_valid[k]=1, searching ptr, ptr+1, ... mod N_REQ.
  - o_req_ready[k]=1 for that k only.
- Transfer = i_req_valid[k] & o_req_ready[k] at a rising edge. Operands of the granted requester are captured on that edge.
- Pointer update on transfer only: ptr <= (k+1) mod N_REQ. Wraps from N_REQ-1 to 0. No transfer -> ptr unchanged.
- At most one transfer per cycle, so throughput is 1 op/cycle. A requester holding valid is granted within N_REQ cycles of continuous non-hold operation (starvation-free).
- Requesters may drop valid without a transfer; the block must not rely on valid staying high.
- Arithmetic, in the capture stage:
  - Sign-extend A and B to IN_W+1 bits and add. The sum cannot overflow at IN_W+1.
  - Format to OUT_W by arithmetic right shift of (IN_W+1-OUT_W) bits: drop LSBs, truncate toward -inf, no rounding, no saturation.
- Pipeline: LAT stages each of {valid, tag, data}.
  - Transfer at edge t -> o_res_valid=1 with matching tag/data in the cycle after edge t+LAT-1 (LAT=2: visible after the second edge following capture).
  - Results appear in grant order. There is no output backpressure; the consumer must accept every pulse.
- o_busy = OR of all pipeline valid bits; it is registered with the stages.
- i_hold asserted mid-stream: the grant is suppressed in that same cycle; already-accepted ops complete on schedule. Deassert -> arbitration resumes from the current ptr.
- Simultaneous valid from all requesters -> strict rotation k=ptr, ptr+1, ...; each granted exactly once per N_REQ cycles.

Test Plan:
- Reset then single op: requester 2 presents A=100, B=28 -> o_req_ready=4'b0100 for one cycle. LAT=2 cycles later o_res_valid=1, tag=2, data=32 (128>>2); o_busy high for exactly 2 cycles.
- Sign/boundary values: A=-1, B=-1 -> data=12'hFFF (-1). A=4095, B=4095 -> data=2047. A=-4096, B=-4096 -> data=-2048 (12'h800). A=1, B=2 -> data=0.
- All four valid continuously for 8 cycles from ptr=0 -> grants 0,1,2,3,0,1,2,3. Results are back-to-back with tags in the same order, one per cycle, each data matching that requester's operands.
- Fairness after a skip: only requesters 1 and 3 valid with ptr=2 -> grant 3 then 1 then 3. Pointer wraps 3->0 and the search reaches 1.
- i_hold=1 for 3 cycles during a 4-request burst -> no o_req_ready in those cycles; in-flight results still emerge on time; after release the next grant is the requester at the saved ptr.
- Async reset asserted mid-burst with 2 ops in flight -> outputs go to 0 immediately without a clock edge; no o_res_valid after release until new transfers occur; first post-reset grant starts at requester 0.

Source files
------------

// File: rtl/add_share_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : add_share_sched
//  Purpose  : Round-robin scheduler sharing one fixed-point adder between
//             N_REQ requesters. Each granted operand pair is sign-extended,
//             added, arithmetically shifted down to OUT_W bits and carried
//             through a LAT-deep {valid, tag, data} delay line. Results are
//             returned in grant order, tagged with the requester index.
//  Revision : 1.0 - initial release
// ============================================================================
module add_share_sched #(
  parameter int N_REQ = 4,
  parameter int IN_W  = 13,
  parameter int OUT_W = 12,
  parameter int LAT   = 2,
  parameter int TAG_W = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  output logic [N_REQ-1:0]        o_req_ready,
  input  logic [N_REQ*IN_W-1:0]   i_req_a,
  input  logic [N_REQ*IN_W-1:0]   i_req_b,
  input  logic                    i_hold,
  output logic                    o_res_valid,
  output logic [TAG_W-1:0]        o_res_tag,
  output logic [OUT_W-1:0]        o_res_data,
  output logic                    o_busy
);

  // Number of LSBs discarded when narrowing the IN_W+1 bit sum to OUT_W.
  localparam int SHIFT = IN_W + 1 - OUT_W;

  logic [TAG_W-1:0] ptr_q;
  logic [TAG_W-1:0] ptr_d;
  logic             gnt_found;
  logic [TAG_W-1:0] gnt_idx;
  logic             xfer;
  logic [IN_W-1:0]  a_sel;
  logic [IN_W-1:0]  b_sel;
  logic [OUT_W-1:0] fmt_d;
  logic             busy_d;
  logic             busy_q;

  logic [LAT-1:0]   vld_q;
  logic [TAG_W-1:0] tag_q [LAT];
  logic [OUT_W-1:0] dat_q [LAT];

  // Round-robin search: first valid requester starting at the pointer.
  always_comb begin
    int               sum;
    logic [TAG_W-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= N_REQ) begin
        sum = sum - N_REQ;
      end
      cand = TAG_W'(sum);
      if (!gnt_found && i_req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Grant is one-hot (or zero when held / nobody asks).
  assign o_req_ready = (gnt_found && !i_hold) ? (N_REQ'(1) << gnt_idx) : '0;
  assign xfer        = |(i_req_valid & o_req_ready);

  // Operand mux for the granted requester, using constant part-selects.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == TAG_W'(k)) begin
        a_sel = i_req_a[k*IN_W +: IN_W];
        b_sel = i_req_b[k*IN_W +: IN_W];
      end
    end
  end

  // Sign-extend by one bit (sum cannot overflow), then floor-shift to OUT_W.
  assign fmt_d = OUT_W'(($signed({a_sel[IN_W-1], a_sel})
                       + $signed({b_sel[IN_W-1], b_sel})) >>> SHIFT);

  // Pointer advances past the granted requester, only on a real transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == TAG_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Busy reflects the valid bits the stages will hold after this edge.
  always_comb begin
    busy_d = xfer;
    for (int s = 0; s < LAT-1; s++) begin
      busy_d = busy_d | vld_q[s];
    end
  end

  // Arbitration pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Capture stage followed by the delay line; reset drops in-flight work.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= '0;
      busy_q <= 1'b0;
      for (int s = 0; s < LAT; s++) begin
        tag_q[s] <= '0;
        dat_q[s] <= '0;
      end
    end else begin
      busy_q   <= busy_d;
      vld_q[0] <= xfer;
      if (xfer) begin
        tag_q[0] <= gnt_idx;
        dat_q[0] <= fmt_d;
      end
      for (int s = 1; s < LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          tag_q[s] <= tag_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end
  end

  assign o_res_valid = vld_q[LAT-1];
  assign o_res_tag   = tag_q[LAT-1];
  assign o_res_data  = dat_q[LAT-1];
  assign o_busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_add_share_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_add_share_sched
//  Purpose  : Scoreboard bench for add_share_sched. The driver applies
//             directed and random requests, predicts grants from the
//             round-robin rule and queues the expected tagged results; an
//             independent monitor matches each result pulse against the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_add_share_sched;

  localparam int N_REQ = 4;
  localparam int IN_W  = 13;
  localparam int OUT_W = 12;
  localparam int LAT   = 2;
  localparam int TAG_W = 2;
  localparam int SHIFT = IN_W + 1 - OUT_W;

  logic                  i_clk;
  logic                  i_rst_n;
  logic [N_REQ-1:0]      i_req_valid;
  logic [N_REQ-1:0]      o_req_ready;
  logic [N_REQ*IN_W-1:0] i_req_a;
  logic [N_REQ*IN_W-1:0] i_req_b;
  logic                  i_hold;
  logic                  o_res_valid;
  logic [TAG_W-1:0]      o_res_tag;
  logic [OUT_W-1:0]      o_res_data;
  logic                  o_busy;

  add_share_sched #(
    .N_REQ(N_REQ), .IN_W(IN_W), .OUT_W(OUT_W), .LAT(LAT), .TAG_W(TAG_W)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_a    (i_req_a),
    .i_req_b    (i_req_b),
    .i_hold     (i_hold),
    .o_res_valid(o_res_valid),
    .o_res_tag  (o_res_tag),
    .o_res_data (o_res_data),
    .o_busy     (o_busy)
  );

  typedef struct {
    int             tag;
    logic [OUT_W-1:0] data;
    int             due;
  } item_t;

  item_t          sb[$];
  int             chk = 0;
  int             err = 0;
  int             cyc = 0;
  int             mptr = 0;
  logic [IN_W-1:0] opa [N_REQ];
  logic [IN_W-1:0] opb [N_REQ];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  // Reference sum: real integer add, floor division by 2^SHIFT, wrap to OUT_W.
  function automatic logic [OUT_W-1:0] ref_sum(input logic [IN_W-1:0] a,
                                               input logic [IN_W-1:0] b);
    logic signed [IN_W-1:0] sa;
    logic signed [IN_W-1:0] sbv;
    int s;
    sa  = a;
    sbv = b;
    s   = int'(sa) + int'(sbv);
    s   = s >>> SHIFT;
    return OUT_W'(s);
  endfunction

  // One clock of stimulus; predicts the grant and queues the expected result.
  task automatic step(input logic [N_REQ-1:0] v, input logic h);
    int g;
    int k;
    i_req_valid = v;
    i_hold      = h;
    for (int j = 0; j < N_REQ; j++) begin
      i_req_a[j*IN_W +: IN_W] = opa[j];
      i_req_b[j*IN_W +: IN_W] = opb[j];
    end
    @(negedge i_clk);
    #1;
    g = -1;
    if (!h) begin
      for (int i = 0; i < N_REQ; i++) begin
        k = (mptr + i) % N_REQ;
        if (g < 0 && v[k]) g = k;
      end
    end
    check("req_ready", int'(o_req_ready), (g < 0) ? 0 : (1 << g));
    if (g >= 0) begin
      sb.push_back('{g, ref_sum(opa[g], opb[g]), cyc + LAT});
      mptr = (g + 1) % N_REQ;
    end
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: every result pulse must match the oldest outstanding op.
  always @(negedge i_clk) begin
    item_t it;
    if (i_rst_n) begin
      check("busy", int'(o_busy), (sb.size() > 0) ? 1 : 0);
      while (sb.size() > 0 && sb[0].due < cyc) begin
        it = sb.pop_front();
        check("res_missing_tag", -1, it.tag);
      end
      if (o_res_valid) begin
        if (sb.size() == 0) begin
          check("res_unexpected", int'(o_res_tag), -1);
        end else begin
          it = sb.pop_front();
          check("res_latency", cyc, it.due);
          check("res_tag", int'(o_res_tag), it.tag);
          check("res_data", int'(o_res_data), int'(it.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n     = 1'b1;
    i_req_valid = '0;
    i_hold      = 1'b0;
    i_req_a     = '0;
    i_req_b     = '0;
    for (int j = 0; j < N_REQ; j++) begin
      opa[j] = '0;
      opb[j] = '0;
    end

    // Power-on reset and reset-state checks.
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_ready", int'(o_req_ready), 0);
    check("rst_valid", int'(o_res_valid), 0);
    check("rst_tag",   int'(o_res_tag), 0);
    check("rst_data",  int'(o_res_data), 0);
    check("rst_busy",  int'(o_busy), 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Single op from requester 2: 100 + 28 = 128 -> 32.
    opa[2] = 13'd100;
    opb[2] = 13'd28;
    step(4'b0100, 1'b0);
    repeat (LAT + 1) step(4'b0000, 1'b0);

    // Boundary values through requester 1.
    opa[1] = 13'h1FFF; opb[1] = 13'h1FFF; step(4'b0010, 1'b0);  // -1 + -1
    opa[1] = 13'h0FFF; opb[1] = 13'h0FFF; step(4'b0010, 1'b0);  // 4095 + 4095
    opa[1] = 13'h1000; opb[1] = 13'h1000; step(4'b0010, 1'b0);  // -4096 + -4096
    opa[1] = 13'd1;    opb[1] = 13'd2;    step(4'b0010, 1'b0);  // 1 + 2
    opa[1] = 13'h1FFF; opb[1] = 13'd0;    step(4'b0010, 1'b0);  // -1 floors to -1
    repeat (LAT + 1) step(4'b0000, 1'b0);

    // Async reset with two ops in flight.
    for (int j = 0; j < N_REQ; j++) begin
      opa[j] = 13'(100 * (j + 1));
      opb[j] = 13'(7 * j);
    end
    step(4'b0001, 1'b0);
    step(4'b1000, 1'b0);
    check("busy_before_reset", int'(o_busy), 1);
    #1;
    i_rst_n     = 1'b0;
    i_req_valid = '0;
    sb.delete();
    mptr = 0;
    #1;
    check("mid_rst_valid", int'(o_res_valid), 0);
    check("mid_rst_tag",   int'(o_res_tag), 0);
    check("mid_rst_data",  int'(o_res_data), 0);
    check("mid_rst_busy",  int'(o_busy), 0);
    check("mid_rst_ready", int'(o_req_ready), 0);
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    repeat (LAT + 2) step(4'b0000, 1'b0);

    // All four valid for 8 cycles from ptr=0: strict rotation.
    for (int c = 0; c < 8; c++) begin
      for (int j = 0; j < N_REQ; j++) begin
        opa[j] = 13'($urandom);
        opb[j] = 13'($urandom);
      end
      step(4'b1111, 1'b0);
    end
    repeat (LAT) step(4'b0000, 1'b0);

    // Fairness after a skip: move ptr to 2, then only 1 and 3 request.
    step(4'b0010, 1'b0);
    repeat (3) step(4'b1010, 1'b0);
    repeat (LAT) step(4'b0000, 1'b0);

    // Hold for three cycles inside a burst.
    step(4'b1111, 1'b0);
    repeat (3) step(4'b1111, 1'b1);
    repeat (3) step(4'b1111, 1'b0);
    repeat (LAT) step(4'b0000, 1'b0);

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      for (int j = 0; j < N_REQ; j++) begin
        opa[j] = 13'($urandom);
        opb[j] = 13'($urandom);
      end
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end

    repeat (LAT + 2) step(4'b0000, 1'b0);
    check("drain_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
`default_nettype wire
